keypad_matrix_emulator: RTL and testbench

Synthesizable model of a 4x4 membrane keypad, acting as the responding end of the keypad scan interface. The keypad scanner drives active-low rows `R` and reads active-low columns `C`. This block receives key-press commands from a bench or self-test sequencer. It then pulls the addressed column low whenever the addressed row is being scanned, with programmable contact bounce, hold time and inter-key gap. It is used for board-level self-test and for closed-loop regression of the keypad scanner.

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/contact_bounce.sv | 40 ++++
 rtl/keypad_matrix_emulator.sv | 150 +++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: press-sequencer states, key-code field layout and
// the named key codes that the scanner and the emulator both use.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } kp_state_e;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Physical layout: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D
  localparam logic [3:0] KEY_1     = 4'h0;
  localparam logic [3:0] KEY_2     = 4'h1;
  localparam logic [3:0] KEY_3     = 4'h2;
  localparam logic [3:0] KEY_START = 4'h3;
  localparam logic [3:0] KEY_4     = 4'h4;
  localparam logic [3:0] KEY_5     = 4'h5;
  localparam logic [3:0] KEY_6     = 4'h6;
  localparam logic [3:0] KEY_7     = 4'h8;
  localparam logic [3:0] KEY_8     = 4'h9;
  localparam logic [3:0] KEY_9     = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_0     = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Only the latched row is looked at, so extra low rows cannot alias a press.
  function automatic logic [3:0] col_drive(input logic       contact,
                                           input logic [3:0] rows,
                                           input logic [3:0] code);
    logic [3:0] cols;
    cols = COL_IDLE;
    if (contact && !rows[code[KEY_ROW_MSB:KEY_ROW_LSB]]) begin
      cols[code[KEY_COL_MSB:KEY_COL_LSB]] = 1'b0;
    end
    return cols;
  endfunction

endpackage

// File: rtl/contact_bounce.sv
// Contact chatter generator: loads a start level, then inverts it every PERIOD
// enabled cycles. Level is valid the cycle after load; no backpressure.
module contact_bounce #(
  parameter int CNT_W  = 16,
  parameter int PERIOD = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_start_lvl,
  input  logic i_en,
  output logic o_lvl
);

  localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_pcnt;
  logic             r_lvl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt <= '0;
      r_lvl  <= 1'b0;
    end else if (i_load) begin
      r_lvl  <= i_start_lvl;
      r_pcnt <= PERIOD_CNT;
    end else if (i_en) begin
      if (r_pcnt <= CNT_ONE) begin
        r_lvl  <= ~r_lvl;
        r_pcnt <= PERIOD_CNT;
      end else begin
        r_pcnt <= r_pcnt - CNT_ONE;
      end
    end
  end

  assign o_lvl = r_lvl;

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 keypad emulator: plays one press (bounce-in, hold, bounce-out, gap) per accepted req.
// Columns respond combinationally to R; req is ignored while busy (no queueing).
module keypad_matrix_emulator #(
  parameter int CNT_W         = 16,
  parameter int BOUNCE_CYCLES = 4,
  parameter int BOUNCE_PERIOD = 1,
  parameter int GAP_CYCLES    = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       R,
  output logic [3:0]       C,
  input  logic             req,
  input  logic [3:0]       key,
  input  logic [CNT_W-1:0] hold_len,
  output logic             busy,
  output logic             done
);

  import keypad_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BNC_CNT    = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_CNT    = CNT_W'(GAP_CYCLES);
  localparam logic             HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam logic             HAS_GAP    = (GAP_CYCLES > 0);

  kp_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic [3:0]       r_key;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic [CNT_W-1:0] w_hold_eff;
  logic             w_load_in;
  logic             w_load_out;
  logic             w_bnc_en;
  logic             w_bnc_lvl;
  logic             w_contact;

  assign w_last     = (r_cnt <= CNT_ONE);
  assign w_hold_eff = (hold_len == '0) ? CNT_ONE : hold_len;
  assign w_load_in  = (r_state == ST_IDLE) && req && HAS_BOUNCE;
  assign w_load_out = (r_state == ST_HOLD) && w_last && HAS_BOUNCE;
  assign w_bnc_en   = (r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT);

  // One chatter generator serves both phases: closed-first on entry, open-first on exit.
  contact_bounce #(
    .CNT_W  (CNT_W),
    .PERIOD (BOUNCE_PERIOD)
  ) u_bounce (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_load      (w_load_in || w_load_out),
    .i_start_lvl (w_load_in),
    .i_en        (w_bnc_en),
    .o_lvl       (w_bnc_lvl)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_key   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_key  <= key;
            r_hold <= w_hold_eff;
            r_busy <= 1'b1;
            if (HAS_BOUNCE) begin
              r_state <= ST_BOUNCE_IN;
              r_cnt   <= BNC_CNT;
            end else begin
              r_state <= ST_HOLD;
              r_cnt   <= w_hold_eff;
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (w_last) begin
            r_state <= ST_HOLD;
            r_cnt   <= r_hold;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (!w_last) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (HAS_BOUNCE) begin
            r_state <= ST_BOUNCE_OUT;
            r_cnt   <= BNC_CNT;
          end else if (HAS_GAP) begin
            r_state <= ST_GAP;
            r_cnt   <= GAP_CNT;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_BOUNCE_OUT: begin
          if (!w_last) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (HAS_GAP) begin
            r_state <= ST_GAP;
            r_cnt   <= GAP_CNT;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // GAP and IDLE leave the contact open, which also forces it open on bounce-out exit.
  assign w_contact = (r_state == ST_HOLD) || (w_bnc_en && w_bnc_lvl);

  assign C    = col_drive(w_contact, R, r_key);
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a no-bounce/short-gap instance and a default instance,
// per-cycle expectations from a timeline model queued and compared at the falling edge.
module tb_keypad_matrix_emulator;

  typedef struct packed {
    logic [3:0] c;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    int         d;
    logic [3:0] key;
    int         hold;
    bit         cyc;
    logic [3:0] r;
    bit         poke;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rr [2];
  logic [3:0]  kk [2];
  logic [3:0]  cc [2];
  logic        rq [2];
  logic        bs [2];
  logic        dn [2];
  logic [15:0] hl [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vt[6];

  always #5 clk = ~clk;

  keypad_matrix_emulator #(
    .CNT_W(16), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(4)
  ) u_dut_nb (
    .CLK(clk), .RST(rst), .R(rr[0]), .C(cc[0]), .req(rq[0]), .key(kk[0]),
    .hold_len(hl[0]), .busy(bs[0]), .done(dn[0])
  );

  keypad_matrix_emulator #(
    .CNT_W(16), .BOUNCE_CYCLES(4), .BOUNCE_PERIOD(1), .GAP_CYCLES(20)
  ) u_dut (
    .CLK(clk), .RST(rst), .R(rr[1]), .C(cc[1]), .req(rq[1]), .key(kk[1]),
    .hold_len(hl[1]), .busy(bs[1]), .done(dn[1])
  );

  function automatic int bnc_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 4 : 20;
  endfunction

  function automatic logic [3:0] rot(input int k);
    case (k % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Expected outputs k cycles after the accepting edge, from the press timeline.
  function automatic exp_t model(input int k, input int b, input int p, input int g,
                                 input int h, input logic [3:0] code, input logic [3:0] r);
    exp_t e;
    bit   ct;
    int   n;
    n  = 2 * b + h + g;
    ct = 1'b0;
    if (k < b)              ct = ((k / p) % 2) == 0;
    else if (k < b + h)     ct = 1'b1;
    else if (k < 2 * b + h) ct = (((k - b - h) / p) % 2) == 1;
    e.busy = (k < n);
    e.done = (k == n);
    e.c    = 4'b1111;
    if (ct && (r[code[3:2]] == 1'b0)) e.c[code[1:0]] = 1'b0;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.c    = 4'b1111;
    e.busy = 1'b0;
    e.done = 1'b0;
    return e;
  endfunction

  task automatic observe(input int d, input string nm, input int idx);
    exp_t e;
    exp_t a;
    @(negedge clk);
    e      = sb.pop_front();
    a.c    = cc[d];
    a.busy = bs[d];
    a.done = dn[d];
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] dut%0d: got C=%b busy=%b done=%b, expected C=%b busy=%b done=%b",
               nm, idx, d, a.c, a.busy, a.done, e.c, e.busy, e.done);
    end
  endtask

  // Entered at posedge+1 with req already driven; the next edge accepts it.
  task automatic check_seq(input int d, input logic [3:0] code, input int h, input bit cyc,
                           input bit poke, input bit b2b, input string nm);
    int b, g, he, n, total, kq;
    b     = bnc_of(d);
    g     = gap_of(d);
    he    = (h == 0) ? 1 : h;
    n     = 2 * b + he + g;
    total = b2b ? 2 * (n + 1) : n + 1;
    @(posedge clk); #1;
    if (!b2b) rq[d] = 1'b0;
    for (int k = 0; k < total; k++) begin
      kq = (k <= n) ? k : k - n - 1;
      if (b2b && k == n + 1) rq[d] = 1'b0;
      if (cyc) rr[d] = rot(k);
      if (poke && k == 3) begin
        rq[d] = 1'b1;
        kk[d] = 4'b1111;
      end
      if (poke && k == n - 3) rq[d] = 1'b0;
      sb.push_back(model(kq, b, 1, g, he, code, rr[d]));
      observe(d, nm, k);
      if (k < total - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    sb.push_back(idle_exp());
    observe(d, {nm, "_after"}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{d: 0, key: 4'b0110, hold: 10, cyc: 1'b0, r: 4'b1101, poke: 1'b0};
    vt[1] = '{d: 0, key: 4'b0110, hold: 10, cyc: 1'b1, r: 4'b1111, poke: 1'b0};
    vt[2] = '{d: 1, key: 4'b0000, hold: 8,  cyc: 1'b0, r: 4'b1110, poke: 1'b0};
    vt[3] = '{d: 1, key: 4'b0000, hold: 8,  cyc: 1'b0, r: 4'b0110, poke: 1'b1};
    vt[4] = '{d: 1, key: 4'b1011, hold: 3,  cyc: 1'b0, r: 4'b1011, poke: 1'b0};
    vt[5] = '{d: 0, key: 4'b1001, hold: 2,  cyc: 1'b0, r: 4'b1101, poke: 1'b0};

    for (int d = 0; d < 2; d++) begin
      rr[d] = 4'b0000;
      kk[d] = 4'b0000;
      rq[d] = 1'b0;
      hl[d] = 16'd0;
    end

    // Reset state, with every row pulled low to show no column responds.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sb.push_back(idle_exp());
      observe(d, "reset", d);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sb.push_back(idle_exp());
      observe(d, "post_reset", d);
    end

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rr[vt[i].d] = vt[i].r;
      kk[vt[i].d] = vt[i].key;
      hl[vt[i].d] = 16'(vt[i].hold);
      rq[vt[i].d] = 1'b1;
      check_seq(vt[i].d, vt[i].key, vt[i].hold, vt[i].cyc, vt[i].poke, 1'b0,
                $sformatf("vec%0d", i));
    end

    // Reset arriving mid-HOLD, then an immediate new press.
    @(posedge clk); #1;
    rr[1] = 4'b1110;
    kk[1] = 4'b0000;
    hl[1] = 16'd8;
    rq[1] = 1'b1;
    @(posedge clk); #1;
    rq[1] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) rst = 1'b1;
      sb.push_back(model(k, 4, 1, 20, 8, 4'b0000, rr[1]));
      observe(1, "rst_pre", k);
      @(posedge clk); #1;
    end
    rst   = 1'b0;
    rr[1] = 4'b1101;
    kk[1] = 4'b0101;
    hl[1] = 16'd2;
    rq[1] = 1'b1;
    sb.push_back(idle_exp());
    observe(1, "rst_idle", 0);
    check_seq(1, 4'b0101, 2, 1'b0, 1'b0, 1'b0, "post_rst");

    // hold_len 0 with req held high: single closed cycle, back-to-back restart.
    @(posedge clk); #1;
    rr[1] = 4'b1101;
    kk[1] = 4'b0101;
    hl[1] = 16'd0;
    rq[1] = 1'b1;
    check_seq(1, 4'b0101, 0, 1'b0, 1'b0, 1'b1, "b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
